// File: rtl/load_writeback_pkg.sv
// Shared constants, size encodings and FSM state type for the load/writeback unit.
// Also provides the alignment helper that the optional misalignment trap uses.
package load_writeback_pkg;

  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Only the low three address bits matter for alignment up to a doubleword.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic ok;
    ok = 1'b1;
    case (size_e'(size))
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      SZ_D:    ok = (addr_lo == 3'b000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_writeback_extend.sv
// Combinational size/sign extender: picks the low 8/16/32/64 bits of the read
// data and sign- or zero-extends them to XLEN. A doubleword ignores i_unsigned.
module load_extend #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_result
);
  import load_writeback_pkg::*;

  logic w_fill;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_result = i_data;
    w_fill   = 1'b0;
    case (size_e'(i_size))
      SZ_B: begin
        w_fill   = ~i_unsigned & i_data[7];
        o_result = {{(XLEN-8){w_fill}}, i_data[7:0]};
      end
      SZ_H: begin
        w_fill   = ~i_unsigned & i_data[15];
        o_result = {{(XLEN-16){w_fill}}, i_data[15:0]};
      end
      SZ_W: begin
        w_fill   = ~i_unsigned & i_data[31];
        o_result = {{(XLEN-32){w_fill}}, i_data[31:0]};
      end
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load unit: latches one load, issues a valid/grant memory read, extends the
// returned data and writes it to the register file for exactly one cycle.
// Optional misalignment trap (err port) enabled by defining LOAD_WB_MISALIGN_TRAP_EN.
module load_writeback #(
  parameter int XLEN    = load_writeback_pkg::XLEN,
  parameter int RADDR_W = load_writeback_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RADDR_W-1:0] req_rd,
  input  logic [XLEN-1:0]    req_base,
  input  logic [XLEN-1:0]    req_offset,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [XLEN-1:0]    mem_addr,
  output logic [1:0]         mem_size,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_rw,
  output logic [XLEN-1:0]    rf_din,
  output logic               busy
`ifdef LOAD_WB_MISALIGN_TRAP_EN
  ,
  output logic               err
`endif
);
  import load_writeback_pkg::*;

  state_e             r_state;
  state_e             w_next;
  logic [RADDR_W-1:0] r_rd;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [XLEN-1:0]    r_addr;
  logic               r_rf_we;
  logic [RADDR_W-1:0] r_rf_rw;
  logic [XLEN-1:0]    r_rf_din;
  logic [XLEN-1:0]    w_addr;
  logic [XLEN-1:0]    w_ext;
  logic               w_accept;
  logic               w_trap;

  // Effective address wraps modulo 2^XLEN; the carry is simply discarded.
  assign w_addr   = req_base + req_offset;
  assign w_accept = (r_state == ST_IDLE) && req_valid;

`ifdef LOAD_WB_MISALIGN_TRAP_EN
  logic r_err;

  assign w_trap = !is_aligned(w_addr[2:0], req_size);
  assign err    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && w_trap;
  end
`else
  assign w_trap = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid && !w_trap) w_next = ST_REQ;
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) w_next = ST_WAIT;
      end
      // mem_rvalid is only looked at here, never in REQ alongside the grant.
      ST_WAIT: if (mem_rvalid) w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .i_data     (mem_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_rf_we    <= 1'b0;
      r_rf_rw    <= '0;
      r_rf_din   <= '0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_accept && !w_trap) begin
        r_rd       <= req_rd;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= w_addr;
      end
      // Writes to x0 still consume the data; only the enable is suppressed.
      if (r_state == ST_WAIT && mem_rvalid) begin
        r_rf_we  <= (r_rd != '0);
        r_rf_rw  <= r_rd;
        r_rf_din <= w_ext;
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_size = r_size;
  assign rf_we    = r_rf_we;
  assign rf_rw    = r_rf_rw;
  assign rf_din   = r_rf_din;

endmodule

// File: tb/tb_load_writeback.sv
// Randomised scoreboard bench for load_writeback: the driver pushes expected
// register-file writes, a monitor thread pops and compares on every rf_we.
`timescale 1ns/1ps
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [63:0] req_base;
  logic [63:0] req_offset;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_req;
  logic        mem_gnt;
  logic [63:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [63:0] rf_din;
  logic        busy;
`ifdef LOAD_WB_MISALIGN_TRAP_EN
  logic        err;
`endif

  load_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_size     (mem_size),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_rw        (rf_rw),
    .rf_din       (rf_din),
    .busy         (busy)
`ifdef LOAD_WB_MISALIGN_TRAP_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]      rd;
    logic [63:0]     din;
    longint unsigned due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: take 8<<size low bits, extend by sign unless unsigned or a full doubleword.
  function automatic logic [63:0] ref_load(input logic [63:0] data, input int size, input bit uns);
    int          nbits;
    logic [63:0] mask;
    nbits = 8 << size;
    if (nbits >= 64) return data;
    mask = (64'd1 << nbits) - 64'd1;
    if (!uns && data[nbits-1]) return (data & mask) | ~mask;
    return data & mask;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_load(input logic [63:0] base, input logic [63:0] off, input logic [1:0] size,
                         input bit uns, input logic [4:0] rd, input logic [63:0] rdata,
                         input int gdly, input int rdly, input bit early_rv);
    logic [63:0] addr;
    exp_t        e;
    addr = base + off;
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    req_valid    = 1'b1;
    req_base     = base;
    req_offset   = off;
    req_size     = size;
    req_unsigned = uns;
    req_rd       = rd;
    if (rd != 5'd0) begin
      e.rd  = rd;
      e.din = ref_load(rdata, int'(size), uns);
      e.due = cyc + 3 + longint'(gdly) + longint'(rdly);
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    req_base   = rnd64();
    req_offset = rnd64();
    req_size   = 2'($urandom);
    req_rd     = 5'($urandom);
    for (int i = 0; i <= gdly; i++) begin
      check("req_mem_req", mem_req, 1);
      check("req_mem_addr", mem_addr, addr);
      check("req_mem_size", mem_size, size);
      check("req_ready_low", req_ready, 0);
      if (i == gdly) begin
        mem_gnt = 1'b1;
        if (early_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rnd64();
        end
      end
      @(negedge clk);
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i <= rdly; i++) begin
      check("wait_mem_req", mem_req, 0);
      check("wait_busy", busy, 1);
      if (i == rdly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_rdata  = rnd64();
    check("wb_rf_we", rf_we, (rd != 5'd0));
    check("wb_ready_low", req_ready, 0);
    @(negedge clk);
    check("post_rf_we", rf_we, 0);
  endtask

  initial begin
    exp_t        m;
    logic [63:0] b, o;
    logic [1:0]  sz;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_rd       = '0;
    req_base     = '0;
    req_offset   = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n && rf_we) begin
            if (sb.size() == 0) begin
              check("unexpected_rf_we", rf_we, 0);
            end else begin
              m = sb.pop_front();
              check("rf_rw", rf_rw, m.rd);
              check("rf_din", rf_din, m.din);
              check("latency", cyc, m.due);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_size", mem_size, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_rw", rf_rw, 0);
    check("rst_rf_din", rf_din, 0);
`ifdef LOAD_WB_MISALIGN_TRAP_EN
    check("rst_err", err, 0);
`endif
    rst_n = 1'b1;

    do_load(64'h1000, 64'h5, 2'd0, 1'b0, 5'd7, 64'h80, 0, 0, 1'b0);
    do_load(64'h2000, 64'h0, 2'd1, 1'b1, 5'd3, 64'hDEAD8001, 0, 0, 1'b0);
    do_load(64'h2000, 64'h0, 2'd1, 1'b0, 5'd4, 64'hDEAD8001, 0, 0, 1'b1);
    do_load(64'h3000, 64'h10, 2'd3, 1'b0, 5'd12, 64'h0123_4567_89AB_CDEF, 4, 3, 1'b0);
    do_load(64'h4000, 64'h8, 2'd3, 1'b0, 5'd0, 64'h1234, 0, 0, 1'b0);
    do_load(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 2'd2, 1'b0, 5'd31, 64'h8000_0000, 1, 0, 1'b0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_base = 64'h5000; req_offset = 64'h0;
    req_size = 2'd3; req_unsigned = 1'b0; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("midwait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", req_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rv_rf_we", rf_we, 0);
    check("late_rv_ready", req_ready, 1);
    @(negedge clk);
    check("late_rv_busy", busy, 0);
    check("late_rv_rf_we2", rf_we, 0);
    do_load(64'h6000, 64'h4, 2'd2, 1'b1, 5'd9, 64'hFFFF_FFFF_F000_0001, 0, 0, 1'b0);

`ifdef LOAD_WB_MISALIGN_TRAP_EN
    @(negedge clk);
    req_valid = 1'b1; req_base = 64'h1000; req_offset = 64'h2;
    req_size = 2'd2; req_unsigned = 1'b0; req_rd = 5'd5;
    @(negedge clk);
    req_valid = 1'b0;
    check("trap_err", err, 1);
    check("trap_mem_req", mem_req, 0);
    check("trap_ready", req_ready, 1);
    @(negedge clk);
    check("trap_err_clear", err, 0);
    check("trap_mem_req2", mem_req, 0);
    check("trap_busy", busy, 0);
`else
    do_load(64'h1000, 64'h2, 2'd2, 1'b0, 5'd5, 64'hCAFE_F00D_8765_4321, 0, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      b  = rnd64() & ~64'h7;
      o  = rnd64() & ~64'h7;
      sz = 2'($urandom_range(0, 3));
      do_load(b, o, sz, 1'($urandom), 5'($urandom), rnd64(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
